// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing, imem handshake, skid buffer and IF/ID register.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect raises fetch_misaligned and halts fetch.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misaligned
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {StFetch, StBuffer, StDrop, StHalt} state_e;
`else
    typedef enum logic [1:0] {StFetch, StBuffer, StDrop} state_e;
`endif

    state_e      r_state, w_state_d;
    logic [31:0] r_pc, w_pc_d;
    logic [31:0] r_drop_addr, w_drop_addr_d;
    logic        r_valid, w_valid_d;
    logic [31:0] r_instr, w_instr_d;
    logic [31:0] r_instr_pc, w_instr_pc_d;
    logic [31:0] r_buf_instr, w_buf_instr_d;
    logic [31:0] r_buf_pc, w_buf_pc_d;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_misaligned, w_misaligned_d;
    logic w_mis_redirect;

    assign w_target       = branch_target;
    assign w_mis_redirect = branch_taken && (branch_target[1:0] != 2'b00);
    assign fetch_misaligned = r_misaligned;
`else
    assign w_target = branch_target & ~32'h0000_0003;
`endif

    assign w_pc_plus4  = r_pc + 32'd4;
    assign imem_req    = (r_state == StFetch) || (r_state == StDrop);
    // While draining a cancelled request the old address stays on the bus; r_pc already holds the target.
    assign imem_addr   = (r_state == StDrop) ? r_drop_addr : r_pc;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign opcode      = r_valid ? r_instr[6:0] : 7'b000_0000;

    always_comb begin
        w_state_d     = r_state;
        w_pc_d        = r_pc;
        w_drop_addr_d = r_drop_addr;
        w_valid_d     = r_valid;
        w_instr_d     = r_instr;
        w_instr_pc_d  = r_instr_pc;
        w_buf_instr_d = r_buf_instr;
        w_buf_pc_d    = r_buf_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
        w_misaligned_d = r_misaligned;
`endif
        unique case (r_state)
            StFetch: begin
                if (branch_taken) begin
                    w_valid_d = 1'b0;
                    w_pc_d    = w_target;
                    if (!imem_ready) begin
                        w_drop_addr_d = r_pc;
                        w_state_d     = StDrop;
                    end
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (w_mis_redirect) begin
                        w_misaligned_d = 1'b1;
                        if (imem_ready) w_state_d = StHalt;
                    end
`endif
                end else if (imem_ready) begin
                    w_pc_d = w_pc_plus4;
                    if (!stall) begin
                        w_valid_d    = 1'b1;
                        w_instr_d    = imem_rdata;
                        w_instr_pc_d = r_pc;
                    end else begin
                        w_buf_instr_d = imem_rdata;
                        w_buf_pc_d    = r_pc;
                        w_state_d     = StBuffer;
                    end
                end else if (!stall) begin
                    w_valid_d = 1'b0;
                end
            end
            StBuffer: begin
                if (branch_taken) begin
                    w_valid_d = 1'b0;
                    w_pc_d    = w_target;
                    w_state_d = StFetch;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (w_mis_redirect) begin
                        w_misaligned_d = 1'b1;
                        w_state_d      = StHalt;
                    end
`endif
                end else if (!stall) begin
                    w_valid_d    = 1'b1;
                    w_instr_d    = r_buf_instr;
                    w_instr_pc_d = r_buf_pc;
                    w_state_d    = StFetch;
                end
            end
            StDrop: begin
                w_valid_d = 1'b0;
                if (branch_taken) begin
                    w_pc_d = w_target;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (w_mis_redirect) w_misaligned_d = 1'b1;
`endif
                end
                if (imem_ready) begin
                    w_state_d = StFetch;
`ifdef FETCH_MISALIGN_TRAP_EN
                    // A pending trap turns the end of the drain into a halt.
                    if (w_misaligned_d) w_state_d = StHalt;
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            StHalt: begin
                w_valid_d = 1'b0;
            end
`endif
            default: begin
                w_state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StFetch;
            r_pc        <= RESET_PC;
            r_drop_addr <= 32'h0;
            r_valid     <= 1'b0;
            r_instr     <= 32'h0;
            r_instr_pc  <= 32'h0;
            r_buf_instr <= 32'h0;
            r_buf_pc    <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misaligned <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_d;
            r_pc        <= w_pc_d;
            r_drop_addr <= w_drop_addr_d;
            r_valid     <= w_valid_d;
            r_instr     <= w_instr_d;
            r_instr_pc  <= w_instr_pc_d;
            r_buf_instr <= w_buf_instr_d;
            r_buf_pc    <= w_buf_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misaligned <= w_misaligned_d;
`endif
        end
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port stall, input, 1, downstream hold request for the IF/ID register.
REQ-005 SHALL have port branch_taken, input, 1, one-cycle redirect strobe.
REQ-006 SHALL have port branch_target, input, 32, redirect address, sampled when branch_taken=1.
REQ-007 SHALL have port imem_req, output, 1, instruction memory request.
REQ-008 SHALL have port imem_addr, output, 32, request address.
REQ-009 SHALL have port imem_ready, input, 1, response strobe; imem_rdata valid this cycle.
REQ-010 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-011 SHALL have port instr_valid, output, 1, IF/ID register holds a live instruction.
REQ-012 SHALL have port instr, output, 32, IF/ID instruction word.
REQ-013 SHALL have port instr_pc, output, 32, PC of instr.
REQ-014 SHALL have port opcode, output, 7, instr[6:0] when instr_valid=1, else 7'b0000000; feeds the control unit.
REQ-015 SHALL have port fetch_misaligned, output, 1, present only when FETCH_MISALIGN_TRAP_EN is defined.

Function
REQ-016 SHALL implement FSM states FETCH, BUFFER, DROP, plus HALT when FETCH_MISALIGN_TRAP_EN is defined.
REQ-017 SHALL drive imem_req=1 in FETCH and DROP, 0 in BUFFER and HALT.
REQ-018 SHALL hold imem_addr constant from request start until the cycle imem_ready=1; next request starts the following cycle.
REQ-019 FETCH, imem_ready=1, stall=0, no redirect: IF/ID <= {1, imem_rdata, pc}; pc <= pc+4; stay FETCH.
REQ-020 FETCH, imem_ready=1, stall=1, no redirect: skid buffer <= {imem_rdata, pc}; pc <= pc+4; go BUFFER; IF/ID held.
REQ-021 FETCH, imem_ready=0, stall=0: instr_valid <= 0 (bubble); stall=1: IF/ID held.
REQ-022 BUFFER, stall=0: IF/ID <= {1, buffer}; go FETCH; stall=1: remain BUFFER, everything held.
REQ-023 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-024 branch_taken=1 SHALL have priority over stall and imem_ready: instr_valid <= 0, skid buffer discarded, pc <= branch_target.
REQ-025 Redirect in FETCH with imem_ready=0: go DROP; keep old imem_addr until imem_ready=1, discard that data, then go FETCH at the new pc.
REQ-026 Redirect in FETCH with imem_ready=1 same cycle: response discarded; stay FETCH; next request uses branch_target.
REQ-027 Redirect in DROP: pc <= newest branch_target; remain DROP until imem_ready=1.
REQ-028 Redirect in BUFFER: go FETCH.
REQ-029 imem_ready while imem_req=0 SHALL be ignored.
REQ-030 Latency: instruction appears on instr the cycle after its imem_ready when stall=0.

Reset
REQ-031 reset=1 SHALL immediately force pc=RESET_PC, state=FETCH, instr_valid=0, instr=0, instr_pc=0, skid buffer=0, fetch_misaligned=0, regardless of clk.
REQ-032 Reset mid-request SHALL abandon it; the first post-reset request SHALL use RESET_PC.

Configuration
REQ-033 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with branch_target[1:0]!=0 sets fetch_misaligned=1, flushes IF/ID, enters HALT (after DROP drains any outstanding request); HALT exits only via reset.
REQ-034 Macro undefined: branch_target[1:0] forced to 2'b00; no fetch_misaligned port; no HALT state.

Verification
REQ-035 Reset release, imem_ready=1 every cycle, stall=0 -> imem_addr 0,4,8,...; instr_pc tracks one cycle later; opcode=imem_rdata[6:0].
REQ-036 stall=1 for 3 cycles while imem_ready=1 at addr 8 -> BUFFER; imem_req=0; on stall=0 instr_pc=8, next imem_addr=12.
REQ-037 branch_taken=1, target 32'h100, imem_ready=0 at addr 0x20 -> imem_addr stays 0x20 until ready; data dropped; next imem_addr=0x100; no instr_valid for 0x20.
REQ-038 branch_taken and imem_ready same cycle, target 0x40 -> instr_valid=0 next cycle, next imem_addr=0x40.
REQ-039 RESET_PC=32'hFFFF_FFFC, two fetches -> imem_addr FFFF_FFFC then 0000_0000.
REQ-040 With FETCH_MISALIGN_TRAP_EN, target 0x102 -> fetch_misaligned=1, imem_req=0, instr_valid=0 until reset; without it, next imem_addr=0x100.
